mc_fetch_unit: RTL and testbench

Program-counter, instruction-register and memory-access stage of the multicycle MIPS core. It sits directly downstream of `controlUnit` and consumes its PC/IR/memory strobes. It owns the architectural PC, the instruction register (IR), the memory data register and the ALUOut register, and runs the single shared-memory handshake. It returns `stall` so the control unit holds its state while a memory access is outstanding.

---
 rtl/mc_pkg.sv | 17 +
 rtl/pc_next_mux.sv | 24 ++
 rtl/mc_fetch_unit.sv | 113 +++++++++++
 tb/tb_mc_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle core: next-PC select encodings, fetch FSM states and
// the default reset PC.
package mc_pkg;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    IDLE,
    BUSY
  } fetch_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select, including the J-type target concatenation.
module pc_next_mux
  import mc_pkg::*;
(
  input  logic [1:0]  pc_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] pc,
  input  logic [25:0] instr_index,
  output logic [31:0] pc_next
);

  always_comb begin
    pc_next = pc;
    unique case (pc_src)
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = alu_out;
      PCSRC_JUMP:   pc_next = {pc[31:28], instr_index, 2'b00};
      PCSRC_HOLD:   pc_next = pc;
      default:      pc_next = pc;
    endcase
  end

endmodule

// File: rtl/mc_fetch_unit.sv
// PC, IR, memory data and ALUOut registers plus the single shared-memory handshake; raises
// stall while an access is outstanding.
module mc_fetch_unit
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        branch,
  input  logic [1:0]  pc_src,
  input  logic        ir_write,
  input  logic        iord,
  input  logic        mem_write,
  input  logic        zero_flag,
  input  logic [31:0] alu_result,
  input  logic [31:0] wdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] mem_data,
  output logic [31:0] alu_out,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, instr_q, mem_data_q, alu_out_q, mem_addr_q, mem_wdata_q;
  logic         mem_we_q, fetch_q, pc_en_q;
  logic [31:0]  pc_next;
  logic         access, pc_en, start, done, pc_load;

  pc_next_mux u_pc_next_mux (
    .pc_src      (pc_src),
    .alu_result  (alu_result),
    .alu_out     (alu_out_q),
    .pc          (pc_q),
    .instr_index (instr_q[25:0]),
    .pc_next     (pc_next)
  );

  always_comb begin
    state_d = state_q;
    access  = ir_write | iord;
    pc_en   = pc_write | (branch & zero_flag);
    start   = 1'b0;
    done    = 1'b0;
    pc_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        start   = access;
        // Without an access the PC moves now; with one it waits for completion.
        pc_load = pc_en & ~access;
        if (access) state_d = BUSY;
      end
      BUSY: begin
        done    = mem_ready;
        pc_load = mem_ready & pc_en_q;
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pc_src == PCSRC_HOLD) pc_load = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      mem_data_q  <= '0;
      alu_out_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      fetch_q     <= 1'b0;
      pc_en_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) alu_out_q <= alu_result;
      if (start) begin
        // Fetch has priority over a simultaneous data access.
        mem_addr_q  <= ir_write ? pc_q : alu_out_q;
        mem_we_q    <= mem_write & iord & ~ir_write;
        mem_wdata_q <= wdata;
        fetch_q     <= ir_write;
        pc_en_q     <= pc_en;
      end
      if (done) begin
        if (fetch_q) instr_q <= mem_rdata;
        else if (!mem_we_q) mem_data_q <= mem_rdata;
        mem_we_q <= 1'b0;
      end
      if (pc_load) pc_q <= pc_next;
    end
  end

  assign pc        = pc_q;
  assign instr     = instr_q;
  assign mem_data  = mem_data_q;
  assign alu_out   = alu_out_q;
  assign stall     = (state_q == BUSY);
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Directed bench for mc_fetch_unit: fetch, store, load, branch, jump, reset mid-access.
module tb_mc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, branch, ir_write, iord, mem_write, zero_flag, mem_ready;
  logic [1:0]  pc_src;
  logic [31:0] alu_result, wdata, mem_rdata;
  logic [31:0] pc, instr, mem_data, alu_out, mem_addr, mem_wdata;
  logic        stall, mem_req, mem_we;

  int checks   = 0;
  int failures = 0;
  int stall_cnt;

  mc_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_write   (pc_write),
    .branch     (branch),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_write  (mem_write),
    .zero_flag  (zero_flag),
    .alu_result (alu_result),
    .wdata      (wdata),
    .pc         (pc),
    .instr      (instr),
    .mem_data   (mem_data),
    .alu_out    (alu_out),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pc_write = 0; branch = 0; ir_write = 0; iord = 0; mem_write = 0;
    zero_flag = 0; mem_ready = 0; pc_src = 2'b00; alu_result = '0; wdata = '0;
    mem_rdata = '0;
    repeat (2) tick();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_stall", {31'b0, stall}, 32'h0);
    check_eq("rst_req", {31'b0, mem_req}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Fetch with PC increment, ready on the third busy cycle
    ir_write = 1; pc_write = 1; pc_src = 2'b00; alu_result = 32'h4;
    tick();
    ir_write = 0; pc_write = 0;
    check_eq("f_addr", mem_addr, 32'h0);
    check_eq("f_we", {31'b0, mem_we}, 32'h0);
    check_eq("f_req", {31'b0, mem_req}, 32'h1);
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (stall) stall_cnt++;
      if (stall && stall_cnt == 3) begin
        mem_ready = 1; mem_rdata = 32'h2008_0005;
      end
      tick();
      mem_ready = 0;
    end
    check_eq("f_stall_cycles", stall_cnt, 32'd3);
    check_eq("f_instr", instr, 32'h2008_0005);
    check_eq("f_pc", pc, 32'h4);

    // Store to 0x40
    alu_result = 32'h40;
    tick();
    check_eq("alu_out", alu_out, 32'h40);
    iord = 1; mem_write = 1; wdata = 32'hDEAD_BEEF;
    tick();
    iord = 0; mem_write = 0;
    check_eq("s_req", {31'b0, mem_req}, 32'h1);
    check_eq("s_we", {31'b0, mem_we}, 32'h1);
    check_eq("s_addr", mem_addr, 32'h40);
    check_eq("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 0;
    check_eq("s_req_done", {31'b0, mem_req}, 32'h0);
    check_eq("s_mem_data", mem_data, 32'h0);
    check_eq("s_pc", pc, 32'h4);

    // Ready while idle must not matter
    mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ready = 0;
    check_eq("idle_ready_instr", instr, 32'h2008_0005);
    check_eq("idle_ready_stall", {31'b0, stall}, 32'h0);

    // Taken branch to ALUOut
    alu_result = 32'h100;
    tick();
    branch = 1; zero_flag = 1; pc_src = 2'b01;
    tick();
    branch = 0;
    check_eq("br_taken", pc, 32'h100);

    // Not-taken branch
    alu_result = 32'h200;
    tick();
    branch = 1; zero_flag = 0; pc_src = 2'b01;
    tick();
    branch = 0;
    check_eq("br_not_taken", pc, 32'h100);

    // HOLD select ignores pc_write
    pc_write = 1; pc_src = 2'b11;
    tick();
    pc_write = 0;
    check_eq("hold", pc, 32'h100);

    // Set up pc and instr, then jump
    pc_write = 1; pc_src = 2'b00; alu_result = 32'h1000_0008;
    tick();
    pc_write = 0;
    check_eq("j_pc_setup", pc, 32'h1000_0008);
    ir_write = 1;
    tick();
    ir_write = 0;
    check_eq("j_fetch_addr", mem_addr, 32'h1000_0008);
    mem_ready = 1; mem_rdata = 32'h0800_0010;
    tick();
    mem_ready = 0;
    check_eq("j_instr", instr, 32'h0800_0010);
    check_eq("j_pc_unchanged", pc, 32'h1000_0008);
    pc_write = 1; pc_src = 2'b10;
    tick();
    pc_write = 0;
    check_eq("jump", pc, 32'h1000_0040);

    // Reset in the middle of a fetch
    ir_write = 1;
    tick();
    ir_write = 0;
    check_eq("r_req_before", {31'b0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("r_req_async", {31'b0, mem_req}, 32'h0);
    check_eq("r_stall_async", {31'b0, stall}, 32'h0);
    check_eq("r_pc_async", pc, 32'h0);
    tick();
    rst_n = 1'b1;
    mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ready = 0;
    check_eq("r_late_ready_instr", instr, 32'h0);
    check_eq("r_late_ready_stall", {31'b0, stall}, 32'h0);

    // Load from 0x80
    alu_result = 32'h80;
    tick();
    iord = 1; mem_write = 0;
    tick();
    iord = 0;
    check_eq("l_addr", mem_addr, 32'h80);
    check_eq("l_we", {31'b0, mem_we}, 32'h0);
    mem_ready = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ready = 0;
    check_eq("l_mem_data", mem_data, 32'hCAFE_0001);

    // Fetch and store strobed together: fetch wins
    ir_write = 1; iord = 1; mem_write = 1;
    tick();
    ir_write = 0; iord = 0; mem_write = 0;
    check_eq("both_addr", mem_addr, 32'h0);
    check_eq("both_we", {31'b0, mem_we}, 32'h0);
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 0;
    check_eq("both_instr", instr, 32'h1234_5678);
    check_eq("both_mem_data", mem_data, 32'hCAFE_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
